intersection_scheduler: RTL and testbench

Two-road intersection phase scheduler that sequences the main-road (A) and side-road (B) signal heads. It arbitrates right-of-way between a side-road vehicle sensor, a latched pedestrian button and an emergency preempt for road A. Phase durations are measured in ticks of a shared enable strobe. The block drives the one-hot light outputs used by the board's signal heads.

---
 rtl/signal_pkg.sv | 18 +
 rtl/phase_timer.sv | 16 +
 rtl/intersection_scheduler.sv | 66 ++++++
 tb/tb_intersection_scheduler.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/signal_pkg.sv
// signal_pkg: shared light encodings, phase enum and default phase timing
package signal_pkg;
  localparam logic [2:0] RED = 3'b001;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN = 3'b100;
  localparam int T_GREEN_MIN_DEF = 8;
  localparam int T_GREEN_MAX_DEF = 20;
  localparam int T_YELLOW_DEF = 3;
  localparam int T_ALLRED_DEF = 1;
  localparam int CW_DEF = 5;
  typedef enum logic [2:0] {A_GRN, A_YEL, AR1, B_GRN, B_YEL, AR2} phase_t;
  function automatic logic [2:0] head_a(input phase_t p);
    return p == A_GRN ? GREEN : p == A_YEL ? YELLOW : RED;
  endfunction
  function automatic logic [2:0] head_b(input phase_t p);
    return p == B_GRN ? GREEN : p == B_YEL ? YELLOW : RED;
  endfunction
endpackage

// File: rtl/phase_timer.sv
// phase_timer: saturating tick counter, cleared on phase change
module phase_timer #(
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          clr,
  output logic [CW-1:0] cnt
);
  // clear wins over counting; hold at all-ones instead of wrapping
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (tick && cnt != '1) cnt <= cnt + 1'b1;
endmodule

// File: rtl/intersection_scheduler.sv
// intersection_scheduler: two-road phase FSM with pedestrian latch and road A preempt
module intersection_scheduler
  import signal_pkg::*;
#(
  parameter int T_GREEN_MIN = T_GREEN_MIN_DEF,
  parameter int T_GREEN_MAX = T_GREEN_MAX_DEF,
  parameter int T_YELLOW = T_YELLOW_DEF,
  parameter int T_ALLRED = T_ALLRED_DEF,
  parameter int CW = CW_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       req_b,
  input  logic       ped_bt,
  input  logic       emg,
  output logic [2:0] light_a,
  output logic [2:0] light_b,
  output logic       walk,
  output logic       ped_pend
);
  phase_t state, next;
  logic [CW-1:0] cnt;
  logic el_gmin, el_gmax, el_y, el_ar, demand;
  assign el_gmin = tick && cnt >= CW'(T_GREEN_MIN - 1);
  assign el_gmax = tick && cnt >= CW'(T_GREEN_MAX - 1);
  assign el_y = tick && cnt >= CW'(T_YELLOW - 1);
  assign el_ar = tick && cnt >= CW'(T_ALLRED - 1);
  assign demand = req_b | ped_pend;
  phase_timer #(.CW(CW)) u_timer (
    .clk (clk),
    .rst (rst),
    .tick(tick),
    .clr (next != state),
    .cnt (cnt)
  );
  // next phase; emg cuts AR1 and B green short but never yellow
  always_comb begin
    next = A_GRN;
    case (state)
      A_GRN: next = el_gmin && demand && !emg ? A_YEL : A_GRN;
      A_YEL: next = el_y ? AR1 : A_YEL;
      AR1:   next = emg ? A_GRN : el_ar ? B_GRN : AR1;
      B_GRN: next = emg || el_gmax || (el_gmin && !req_b) ? B_YEL : B_GRN;
      B_YEL: next = el_y ? AR2 : B_YEL;
      AR2:   next = el_ar ? A_GRN : AR2;
      default: next = A_GRN;
    endcase
  end
  // state, pedestrian latch and lights decoded from the next phase
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= A_GRN;
      ped_pend <= 1'b0;
      light_a <= GREEN;
      light_b <= RED;
      walk <= 1'b0;
    end else begin
      state <= next;
      ped_pend <= next == B_GRN && state != B_GRN ? 1'b0 :
                  ped_bt && state != B_GRN ? 1'b1 : ped_pend;
      light_a <= head_a(next);
      light_b <= head_b(next);
      walk <= next == B_GRN;
    end
endmodule

// File: tb/tb_intersection_scheduler.sv
// tb_intersection_scheduler: scoreboard bench against a cycle model of the phase rules
module tb_intersection_scheduler;
  import signal_pkg::*;
  localparam int GMIN = 8, GMAX = 20, TY = 3, TAR = 1;
  localparam logic [2:0] R = 3'b001, Y = 3'b010, G = 3'b100;
  logic clk = 1'b0, rst = 1'b1, tick = 1'b0, req_b = 1'b0, ped_bt = 1'b0, emg = 1'b0;
  logic [2:0] light_a, light_b;
  logic walk, ped_pend;
  int checks = 0, failures = 0, gb = 0, wc = 0;
  phase_t m_ph = A_GRN;
  int m_cnt = 0;
  logic m_pp = 1'b0;
  logic [7:0] sbq[$];

  always #5 clk = ~clk;

  intersection_scheduler #(
    .T_GREEN_MIN(GMIN), .T_GREEN_MAX(GMAX), .T_YELLOW(TY), .T_ALLRED(TAR), .CW(5)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .req_b(req_b), .ped_bt(ped_bt), .emg(emg),
    .light_a(light_a), .light_b(light_b), .walk(walk), .ped_pend(ped_pend)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic t, input logic rb, input logic pb, input logic e);
    phase_t nx;
    logic egmin, egmax, ey, ear;
    tick = t; req_b = rb; ped_bt = pb; emg = e;
    egmin = t && m_cnt >= GMIN - 1;
    egmax = t && m_cnt >= GMAX - 1;
    ey = t && m_cnt >= TY - 1;
    ear = t && m_cnt >= TAR - 1;
    nx = m_ph;
    case (m_ph)
      A_GRN: if (egmin && (rb || m_pp) && !e) nx = A_YEL;
      A_YEL: if (ey) nx = AR1;
      AR1:   if (e) nx = A_GRN; else if (ear) nx = B_GRN;
      B_GRN: if (e || egmax || (egmin && !rb)) nx = B_YEL;
      B_YEL: if (ey) nx = AR2;
      AR2:   if (ear) nx = A_GRN;
      default: nx = A_GRN;
    endcase
    if (nx == B_GRN && m_ph != B_GRN) m_pp = 1'b0;
    else if (pb && m_ph != B_GRN) m_pp = 1'b1;
    m_cnt = nx != m_ph ? 0 : (t && m_cnt < 31) ? m_cnt + 1 : m_cnt;
    m_ph = nx;
    sbq.push_back({nx == A_GRN ? G : nx == A_YEL ? Y : R,
                   nx == B_GRN ? G : nx == B_YEL ? Y : R,
                   nx == B_GRN, m_pp});
    @(posedge clk); #1;
    chk("out", 32'({light_a, light_b, walk, ped_pend}), 32'(sbq.pop_front()));
    chk("safe", 32'(light_a != R && light_b != R), 0);
    if (light_b == G) gb++;
    if (walk) wc++;
    @(negedge clk);
  endtask

  task automatic run(input int n, input logic rb, input logic pb, input logic e);
    for (int i = 0; i < n; i++) step(1'b1, rb, pb, e);
  endtask

  task automatic do_reset();
    tick = 1'b0; req_b = 1'b0; ped_bt = 1'b0; emg = 1'b0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk("rst_out", 32'({light_a, light_b, walk, ped_pend}), 32'({G, R, 2'b00}));
    chk("rst_cnt", 32'(dut.cnt), 0);
    m_ph = A_GRN; m_cnt = 0; m_pp = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    do_reset();
    run(40, 1'b0, 1'b0, 1'b0);
    chk("cnt_sat", 32'(dut.cnt), 31);
    chk("idle_a", 32'(light_a), 32'(G));

    do_reset();
    run(2, 1'b0, 1'b0, 1'b0);
    run(5, 1'b1, 1'b0, 1'b0);
    chk("a_grn_t6", 32'(light_a), 32'(G));
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("a_yel_t7", 32'(light_a), 32'(Y));
    run(3, 1'b1, 1'b0, 1'b0);
    chk("ar1", 32'({light_a, light_b}), 32'({R, R}));
    gb = 0;
    run(1, 1'b1, 1'b0, 1'b0);
    chk("b_grn_4", 32'(light_b), 32'(G));
    run(10, 1'b0, 1'b0, 1'b0);
    chk("b_min", gb, 8);
    run(4, 1'b0, 1'b0, 1'b0);
    chk("back_a", 32'(light_a), 32'(G));

    do_reset();
    wc = 0;
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("pp_set", 32'(ped_pend), 1);
    run(12, 1'b0, 1'b0, 1'b0);
    chk("walk_on", 32'(walk), 1);
    chk("pp_clr", 32'(ped_pend), 0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("pp_ign", 32'(ped_pend), 0);
    run(10, 1'b0, 1'b0, 1'b0);
    chk("walk_len", wc, 8);
    chk("walk_off", 32'(walk), 0);

    do_reset();
    gb = 0;
    run(40, 1'b1, 1'b0, 1'b0);
    chk("b_max", gb, 20);
    chk("max_back_a", 32'(light_a), 32'(G));

    do_reset();
    run(14, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    chk("emg_byel", 32'(light_b), 32'(Y));
    run(3, 1'b1, 1'b0, 1'b1);
    chk("emg_ar2", 32'({light_a, light_b}), 32'({R, R}));
    run(21, 1'b1, 1'b0, 1'b1);
    chk("emg_hold", 32'(light_a), 32'(G));
    run(4, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    chk("emg_ar1", 32'(light_a), 32'(G));

    do_reset();
    run(32, 1'b1, 1'b0, 1'b0);
    chk("pre_rst_byel", 32'(light_b), 32'(Y));
    do_reset();

    run(5, 1'b0, 1'b0, 1'b0);
    force dut.state = phase_t'(3'd7);
    @(posedge clk); #1;
    chk("ill_out", 32'({light_a, light_b, walk}), 32'({G, R, 1'b0}));
    chk("ill_cnt", 32'(dut.cnt), 0);
    @(negedge clk);
    release dut.state;
    @(posedge clk); #1;
    chk("ill_state", 32'(dut.state), 32'(A_GRN));
    chk("ill_cnt2", 32'(dut.cnt), 0);
    @(negedge clk);
    m_ph = A_GRN; m_cnt = 0;
    run(5, 1'b0, 1'b0, 1'b0);

    do_reset();
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 19) == 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
